// File: rtl/costas_track_loop.sv
// BPSK Costas carrier-recovery loop: LUT NCO, I/Q mixers, integrate-and-dump, phase detector,
// PI loop filter with two gain gears selected by a saturating lock counter.
module costas_track_loop #(
    parameter int DIN_W     = 8,
    parameter int NCO_W     = 30,
    parameter int LUT_AW    = 10,
    parameter int TRIG_W    = 8,
    parameter int DUMP_LOG2 = 4,
    parameter int LF_W      = 26,
    parameter int PD_MODE   = 0,
    parameter int KP_ACQ    = 4,
    parameter int KI_ACQ    = 10,
    parameter int KP_TRK    = 7,
    parameter int KI_TRK    = 14,
    parameter int LOCK_THR  = 0,
    parameter int LOCK_CNT  = 8
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic signed [DIN_W-1:0]                     din,
    input  logic                                        din_valid,
    input  logic        [NCO_W-1:0]                     freq_word,
    output logic signed [DIN_W+TRIG_W+DUMP_LOG2-1:0]    di,
    output logic signed [DIN_W+TRIG_W+DUMP_LOG2-1:0]    dq,
    output logic                                        dv,
    output logic signed [LF_W-1:0]                      df,
    output logic                                        locked
);
    localparam int ACC_W  = DIN_W + TRIG_W + DUMP_LOG2;
    localparam int PROD_W = DIN_W + TRIG_W;
    localparam int PD_PW  = 2 * ACC_W;
    localparam int SUM_W  = ((ACC_W > LF_W) ? ACC_W : LF_W) + 2;
    localparam int LT_W   = ACC_W + 3;
    localparam int CNT_W  = $clog2(LOCK_CNT + 1);

    localparam logic signed [SUM_W-1:0] LF_MAX = {{(SUM_W-LF_W+1){1'b0}}, {(LF_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] LF_MIN = ~LF_MAX;
    localparam logic [CNT_W-1:0]        CNT_MAX = CNT_W'(LOCK_CNT);

    localparam logic [0:0] ST_ACQ = 1'b0;
    localparam logic [0:0] ST_TRK = 1'b1;

    // Sine table entry, rounded half away from zero, computed at elaboration.
    function automatic logic signed [TRIG_W-1:0] sin_entry(input int k);
        real amp;
        real x;
        amp = real'((1 << (TRIG_W - 1)) - 1);
        x   = amp * $sin(2.0 * 3.14159265358979323846 * real'(k) / real'(1 << LUT_AW));
        if (x >= 0.0)
            return TRIG_W'($rtoi(x + 0.5));
        else
            return TRIG_W'(-$rtoi(0.5 - x));
    endfunction

    function automatic logic signed [LF_W-1:0] sat_lf(input logic signed [SUM_W-1:0] x);
        if (x > LF_MAX)
            return LF_W'(LF_MAX);
        else if (x < LF_MIN)
            return LF_W'(LF_MIN);
        else
            return LF_W'(x);
    endfunction

    logic signed [TRIG_W-1:0] sin_rom [1 << LUT_AW];

    for (genvar k = 0; k < (1 << LUT_AW); k++) begin : g_rom
        assign sin_rom[k] = sin_entry(k);
    end

    logic        [NCO_W-1:0]  phase;
    logic        [NCO_W-1:0]  df_ext;
    logic        [LUT_AW-1:0] sin_addr;
    logic        [LUT_AW-1:0] cos_addr;
    logic                     s1_valid;
    logic signed [DIN_W-1:0]  din_r;
    logic signed [TRIG_W-1:0] sin_r;
    logic signed [TRIG_W-1:0] cos_r;

    assign df_ext   = {{(NCO_W-LF_W){df[LF_W-1]}}, df};
    assign sin_addr = phase[NCO_W-1 -: LUT_AW];
    assign cos_addr = sin_addr + LUT_AW'(1 << (LUT_AW - 2));

    // Stage 1: register the sample with its sine/cosine; phase only advances on accepted samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase    <= '0;
            s1_valid <= 1'b0;
            din_r    <= '0;
            sin_r    <= '0;
            cos_r    <= '0;
        end else begin
            s1_valid <= din_valid;
            if (din_valid) begin
                din_r <= din;
                sin_r <= sin_rom[sin_addr];
                cos_r <= sin_rom[cos_addr];
                phase <= phase + freq_word + df_ext;
            end
        end
    end

    logic                     s2_valid;
    logic signed [PROD_W-1:0] prod_i;
    logic signed [PROD_W-1:0] prod_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            prod_i   <= '0;
            prod_q   <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                prod_i <= PROD_W'(din_r) * PROD_W'(cos_r);
                prod_q <= -(PROD_W'(din_r) * PROD_W'(sin_r));
            end
        end
    end

    logic signed [ACC_W-1:0]     acc_i;
    logic signed [ACC_W-1:0]     acc_q;
    logic signed [ACC_W-1:0]     sum_i;
    logic signed [ACC_W-1:0]     sum_q;
    logic        [DUMP_LOG2-1:0] dump_cnt;

    assign sum_i = acc_i + ACC_W'(prod_i);
    assign sum_q = acc_q + ACC_W'(prod_q);

    // Stage 3: integrate-and-dump; the last product of a block goes straight into the dump.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_i    <= '0;
            acc_q    <= '0;
            dump_cnt <= '0;
            di       <= '0;
            dq       <= '0;
            dv       <= 1'b0;
        end else begin
            dv <= 1'b0;
            if (s2_valid) begin
                dump_cnt <= dump_cnt + DUMP_LOG2'(1);
                if (&dump_cnt) begin
                    di    <= sum_i;
                    dq    <= sum_q;
                    acc_i <= '0;
                    acc_q <= '0;
                    dv    <= 1'b1;
                end else begin
                    acc_i <= sum_i;
                    acc_q <= sum_q;
                end
            end
        end
    end

    logic                    pd_valid;
    logic signed [ACC_W-1:0] pd;
    logic                    lock_ok;
    logic signed [LT_W-1:0]  abs_i;
    logic signed [LT_W-1:0]  abs_q;
    logic signed [LT_W-1:0]  lock_metric;

    assign abs_i       = di[ACC_W-1] ? -LT_W'(di) : LT_W'(di);
    assign abs_q       = dq[ACC_W-1] ? -LT_W'(dq) : LT_W'(dq);
    assign lock_metric = abs_i - (abs_q <<< 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            pd_valid <= 1'b0;
            pd       <= '0;
            lock_ok  <= 1'b0;
        end else begin
            pd_valid <= dv;
            if (dv) begin
                if (PD_MODE == 1)
                    pd <= ACC_W'((PD_PW'(di) * PD_PW'(dq)) >>> (ACC_W - 1));
                else
                    pd <= di[ACC_W-1] ? -dq : dq;
                lock_ok <= lock_metric > LT_W'(LOCK_THR);
            end
        end
    end

    logic        [0:0]       state;
    logic        [CNT_W-1:0] cnt;
    logic        [CNT_W-1:0] cnt_next;
    logic signed [LF_W-1:0]  integ;
    logic signed [LF_W-1:0]  integ_new;
    logic signed [SUM_W-1:0] integ_sum;
    logic signed [SUM_W-1:0] df_sum;
    logic        [5:0]       sh_kp;
    logic        [5:0]       sh_ki;
    logic signed [ACC_W-1:0] pd_p;
    logic signed [ACC_W-1:0] pd_i;

    assign sh_kp     = (state == ST_ACQ) ? 6'(KP_ACQ) : 6'(KP_TRK);
    assign sh_ki     = (state == ST_ACQ) ? 6'(KI_ACQ) : 6'(KI_TRK);
    assign pd_p      = pd >>> sh_kp;
    assign pd_i      = pd >>> sh_ki;
    assign integ_sum = SUM_W'(integ) + SUM_W'(pd_i);
    assign integ_new = sat_lf(integ_sum);
    assign df_sum    = SUM_W'(integ_new) + SUM_W'(pd_p);

    always_comb begin
        cnt_next = cnt;
        if (lock_ok) begin
            if (cnt != CNT_MAX)
                cnt_next = cnt + CNT_W'(1);
        end else if (cnt != '0) begin
            cnt_next = cnt - CNT_W'(1);
        end
    end

    // Loop filter and gear FSM update together once per dump; the integrator survives gear changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_ACQ;
            cnt   <= '0;
            integ <= '0;
            df    <= '0;
        end else if (pd_valid) begin
            integ <= integ_new;
            df    <= sat_lf(df_sum);
            cnt   <= cnt_next;
            if (state == ST_ACQ && cnt_next == CNT_MAX)
                state <= ST_TRK;
            else if (state == ST_TRK && cnt_next == '0)
                state <= ST_ACQ;
        end
    end

    assign locked = (state == ST_TRK);

endmodule
